// File: rtl/elk_shift_seq_pkg.sv
// Shared constants and types for the elk shift command sequencer.
package elk_shift_seq_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_VALUE  = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_RESULT = 3'd3;
    localparam logic [2:0] REG_CLEAR  = 3'd4;

    localparam int BIT_BUSY      = 0;
    localparam int BIT_CMD_FULL  = 1;
    localparam int BIT_CMD_EMPTY = 2;
    localparam int BIT_RES_FULL  = 3;
    localparam int BIT_RES_EMPTY = 4;
    localparam int BIT_OVF       = 5;
    localparam int BIT_UNF       = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef struct packed {
        logic [31:0] val;
        logic        dir;
        logic [4:0]  amt;
    } cmd_t;

endpackage

// File: rtl/elk_shift_seq_if.sv
// Slot bus connecting the CPU side to the shift sequencer.
interface elk_shift_seq_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/elk_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; caller must never push when full or pop when empty.
module elk_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/elk_shift_seq.sv
// Shift job sequencer: CPU queues jobs over the slot bus, a bit-serial engine runs them.
//  state   | meaning
//  S_IDLE  | waiting for a queued job; pops it when present
//  S_SHIFT | shifting val one bit per cycle until cnt reaches zero
//  S_DONE  | pushing val into the result FIFO; holds while it is full
module elk_shift_seq
    import elk_shift_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    elk_shift_seq_if.slave       bus
);
    localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
    localparam int RES_CW = $clog2(RES_DEPTH) + 1;

    logic [2:0]        reg_sel;
    logic              bus_wr;
    logic              bus_rd;
    logic              unused_addr;
    logic [31:0]       stage;
    logic              ovf;
    logic              unf;
    logic [1:0]        state;
    logic [31:0]       val;
    logic              dir;
    logic [4:0]        cnt;

    cmd_t              cmd_in;
    cmd_t              cmd_head;
    logic              cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CMD_CW-1:0] cmd_count;
    logic [31:0]       res_head;
    logic              res_push, res_pop, res_full, res_empty;
    logic [RES_CW-1:0] res_count;
    logic [31:0]       status;

    assign reg_sel     = bus.addr[2:0];
    assign unused_addr = ^bus.addr[4:3];
    assign bus_wr      = bus.cs && bus.write;
    assign bus_rd      = bus.cs && bus.read;

    // Full/empty are pre-edge flags, so a push to a full FIFO is dropped even if the engine pops.
    assign cmd_in   = {stage, bus.wr_data[5:0]};
    assign cmd_push = bus_wr && (reg_sel == REG_CTRL) && !cmd_full;
    assign cmd_pop  = (state == S_IDLE) && !cmd_empty;
    assign res_push = (state == S_DONE) && !res_full;
    assign res_pop  = bus_rd && (reg_sel == REG_RESULT) && !res_empty;

    elk_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .reset(reset), .push(cmd_push), .pop(cmd_pop), .din(cmd_in),
        .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    elk_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .reset(reset), .push(res_push), .pop(res_pop), .din(val),
        .dout(res_head), .full(res_full), .empty(res_empty), .count(res_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (bus_wr && reg_sel == REG_VALUE) stage <= bus.wr_data;
            if (bus_wr && reg_sel == REG_CTRL && cmd_full)
                ovf <= 1'b1;
            else if (bus_wr && reg_sel == REG_CLEAR && bus.wr_data[0])
                ovf <= 1'b0;
            if (bus_rd && reg_sel == REG_RESULT && res_empty)
                unf <= 1'b1;
            else if (bus_wr && reg_sel == REG_CLEAR && bus.wr_data[1])
                unf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            val   <= '0;
            dir   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (!cmd_empty) begin
                    val   <= cmd_head.val;
                    dir   <= cmd_head.dir;
                    cnt   <= cmd_head.amt;
                    state <= S_SHIFT;
                end
                S_SHIFT: if (cnt != '0) begin
                    val <= dir ? (val << 1) : (val >> 1);
                    cnt <= cnt - 1'b1;
                end else begin
                    state <= S_DONE;
                end
                S_DONE: if (!res_full) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[BIT_BUSY]      = (state != S_IDLE);
        status[BIT_CMD_FULL]  = cmd_full;
        status[BIT_CMD_EMPTY] = cmd_empty;
        status[BIT_RES_FULL]  = res_full;
        status[BIT_RES_EMPTY] = res_empty;
        status[BIT_OVF]       = ovf;
        status[BIT_UNF]       = unf;
        status[11:8]          = 4'(cmd_count);
        status[15:12]         = 4'(res_count);
    end

    always_comb begin
        bus.rd_data = '0;
        case (reg_sel)
            REG_STATUS: bus.rd_data = status;
            REG_VALUE:  bus.rd_data = stage;
            REG_RESULT: bus.rd_data = res_empty ? 32'h0 : res_head;
            default:    bus.rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_elk_shift_seq.sv
// Self-checking bench for elk_shift_seq: vector table plus corner-case sequences.
module tb_elk_shift_seq;
    logic clk;
    logic reset;

    elk_shift_seq_if bus ();

    elk_shift_seq #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] val;
        logic [31:0] ctrl;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] r;
    int          k;
    bit          ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        #1;
        d = bus.rd_data;
        @(posedge clk);
        #1;
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reads STATUS once per cycle until (STATUS & mask) == want; k counts reads before the hit.
    task automatic poll_status(input logic [31:0] mask, input logic [31:0] want,
                               output int cycles, output bit found);
        logic [31:0] s;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            bus_read(5'd0, s);
            if ((s & mask) == want) begin
                found = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic pop_check(input string name, input logic [4:0] a);
        logic [31:0] d;
        logic [31:0] e;
        bus_read(a, d);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=<no result expected>", name, d);
        end else begin
            e = sb.pop_front();
            check(name, d, e);
        end
    endtask

    task automatic submit(input logic [31:0] v, input logic [31:0] c, input bit accepted);
        bus_write(5'd1, v);
        bus_write(5'd2, c);
        if (accepted)
            sb.push_back(c[5] ? (v << c[4:0]) : (v >> c[4:0]));
    endtask

    initial begin
        vecs[0] = '{32'h0000_00F0, 32'h0000_0004, 32'h0000_000F};
        vecs[1] = '{32'h8000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[2] = '{32'h1234_5678, 32'h0000_0000, 32'h1234_5678};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_001F, 32'h0000_0001};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_003F, 32'h8000_0000};
        vecs[5] = '{32'hA5A5_A5A5, 32'h0000_0028, 32'hA5A5_A500};
        vecs[6] = '{32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_DEAD};
        vecs[7] = '{32'h0000_0080, 32'hFFFF_FFC3, 32'h0000_0010};

        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state, empty RESULT read, unmapped reads, CLEAR of unf.
        bus_read(5'd0, r);  check("reset_status", r, 32'h0000_0014);
        bus_read(5'd3, r);  check("empty_result", r, 32'h0);
        bus_read(5'd0, r);  check("unf_status", r, 32'h0000_0054);
        bus_read(5'd7, r);  check("unmapped_rd7", r, 32'h0);
        bus_write(5'd4, 32'h2);
        bus_read(5'd0, r);  check("unf_cleared", r, 32'h0000_0014);

        // Vector table: data and pop-to-visible latency for each job.
        foreach (vecs[i]) begin
            bus_write(5'd1, vecs[i].val);
            bus_read(5'd1, r);  check($sformatf("value_rb%0d", i), r, vecs[i].val);
            bus_read(5'd2, r);  check($sformatf("ctrl_rd0_%0d", i), r, 32'h0);
            bus_write(5'd2, vecs[i].ctrl);
            sb.push_back(vecs[i].exp);
            poll_status(32'h10, 32'h0, k, ok);
            check($sformatf("vec%0d_arrived", i), 32'(ok), 32'd1);
            check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].ctrl[4:0]) + 32'd3);
            pop_check($sformatf("vec%0d_result", i), 5'h1B);
        end
        bus_read(5'd0, r);  check("after_table", r, 32'h0000_0014);

        // Overflow: engine stalls in DONE with result FIFO full, cmd FIFO fills, 10th job dropped.
        for (int j = 0; j < 9; j++) submit(32'h1000 + j, 32'h0, 1'b1);
        tick(20);
        bus_read(5'd0, r);  check("stall_status", r, 32'h0000_440B);
        submit(32'h1009, 32'h0, 1'b0);
        bus_read(5'd0, r);  check("ovf_status", r, 32'h0000_442B);
        bus_read(5'd1, r);  check("stage_10th", r, 32'h0000_1009);
        for (int j = 0; j < 9; j++) begin
            poll_status(32'h10, 32'h0, k, ok);
            check($sformatf("drain%0d_arrived", j), 32'(ok), 32'd1);
            pop_check($sformatf("drain%0d", j), 5'd3);
        end
        bus_read(5'd0, r);  check("drained_status", r, 32'h0000_0034);
        bus_write(5'd4, 32'h1);
        bus_read(5'd0, r);  check("ovf_cleared", r, 32'h0000_0014);

        // Reset mid-shift discards the job and all state.
        submit(32'hFFFF_FFFF, 32'h1F, 1'b0);
        tick(5);
        bus_read(5'd0, r);  check("busy_mid_shift", r, 32'h0000_0015);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        bus_read(5'd0, r);  check("post_reset_status", r, 32'h0000_0014);
        bus_read(5'd1, r);  check("post_reset_stage", r, 32'h0);
        tick(40);
        bus_read(5'd0, r);  check("no_late_result", r, 32'h0000_0014);

        // Result FIFO at count 2: engine push and CPU pop on the same edge.
        submit(32'hCAFE_0001, 32'h0, 1'b1);
        submit(32'hCAFE_0002, 32'h0, 1'b1);
        poll_status(32'h0000_F000, 32'h0000_2000, k, ok);
        check("res_count2_reached", 32'(ok), 32'd1);
        submit(32'h0000_0F00, 32'h04, 1'b1);
        tick(6);
        pop_check("coincide_pop", 5'd3);
        bus_read(5'd0, r);  check("coincide_status", r, 32'h0000_2004);
        pop_check("coincide_next", 5'd3);
        pop_check("coincide_last", 5'd3);
        bus_read(5'd0, r);  check("final_status", r, 32'h0000_0014);

        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: actual=%0d required=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
